// File: rtl/store_pkg.sv
// store_pkg: funct3 codes, byte-lane base masks and FSM state encoding for the store unit.
package store_pkg;
    localparam int ADDR_W = 32;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
endpackage

// File: rtl/store_if.sv
// store_if: request side, memory write port and status of the store unit.
interface store_if;
    import store_pkg::*;
    logic req_valid;
    logic req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0] req_data;
    logic [2:0] req_funct3;
    logic mem_valid;
    logic mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0] mem_wstrb;
    logic done;
    logic err;
    logic busy;
    modport master (
        output req_valid, req_addr, req_data, req_funct3, mem_ready,
        input req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err, busy
    );
    modport slave (
        input req_valid, req_addr, req_data, req_funct3, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err, busy
    );
endinterface

// File: rtl/store_align.sv
// store_align: lane-aligns store data and byte strobes across a 64-bit two-word window.
module store_align
    import store_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [2:0] funct3,
    input  logic [1:0] off,
    output logic [63:0] wide64,
    output logic [7:0] mask8,
    output logic misaligned,
    output logic illegal
);
    logic [3:0] base;
    logic [31:0] masked;
    always_comb begin
        base = funct3 == F3_SB ? MASK_B : funct3 == F3_SH ? MASK_H : funct3 == F3_SW ? MASK_W : 4'b0000;
        masked = data & {{8{base[3]}}, {8{base[2]}}, {8{base[1]}}, {8{base[0]}}};
        wide64 = {32'b0, masked} << {off, 3'b000};
        mask8 = {4'b0000, base} << off;
        illegal = base == 4'b0000;
        misaligned = (funct3 == F3_SH && off[0]) || (funct3 == F3_SW && off != 2'b00);
    end
endmodule

// File: rtl/store_unit.sv
// store_unit: formats SB/SH/SW stores and writes them over a valid/ready memory port.
// STORE_SPLIT_EN: misaligned SH/SW become one or two beats instead of an err pulse.
module store_unit
    import store_pkg::*;
(
    input logic clk,
    input logic rst,
    store_if.slave bus
);
    state_t state, state_nx;
    logic [63:0] wide64;
    logic [7:0] mask8;
    logic misaligned, illegal, reject, has_hi, accept;
    logic [ADDR_W-3:0] word_q;
    logic [31:0] lo_data_q;
    logic [3:0] lo_strb_q;
    logic err_q;
    store_align u_align (
        .data(bus.req_data),
        .funct3(bus.req_funct3),
        .off(bus.req_addr[1:0]),
        .wide64(wide64),
        .mask8(mask8),
        .misaligned(misaligned),
        .illegal(illegal)
    );
    assign accept = bus.req_valid && state == IDLE;
`ifdef STORE_SPLIT_EN
    logic [31:0] hi_data_q;
    logic [3:0] hi_strb_q;
    logic unused_mis;
    assign unused_mis = misaligned;
    assign reject = illegal;
    assign has_hi = |hi_strb_q;
`else
    logic unused_hi;
    assign unused_hi = ^{wide64[63:32], mask8[7:4]};
    assign reject = illegal || misaligned;
    assign has_hi = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Request is captured once; the beat outputs are muxed from these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            lo_data_q <= '0;
            lo_strb_q <= '0;
            err_q <= 1'b0;
`ifdef STORE_SPLIT_EN
            hi_data_q <= '0;
            hi_strb_q <= '0;
`endif
        end else if (accept) begin
            word_q <= bus.req_addr[ADDR_W-1:2];
            lo_data_q <= wide64[31:0];
            lo_strb_q <= mask8[3:0];
            err_q <= reject;
`ifdef STORE_SPLIT_EN
            hi_data_q <= wide64[63:32];
            hi_strb_q <= mask8[7:4];
`endif
        end
    end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE: state_nx = bus.req_valid ? (reject ? DONE : LO) : IDLE;
            LO: state_nx = bus.mem_ready ? (has_hi ? HI : DONE) : LO;
            HI: state_nx = bus.mem_ready ? DONE : HI;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.req_ready = state == IDLE;
        bus.busy = state != IDLE;
        bus.done = state == DONE && !err_q;
        bus.err = state == DONE && err_q;
        bus.mem_valid = state == LO || state == HI;
`ifdef STORE_SPLIT_EN
        bus.mem_addr = state == HI ? {word_q + (ADDR_W-2)'(1), 2'b00} : {word_q, 2'b00};
        bus.mem_wdata = state == HI ? hi_data_q : lo_data_q;
        bus.mem_wstrb = state == HI ? hi_strb_q : lo_strb_q;
`else
        bus.mem_addr = {word_q, 2'b00};
        bus.mem_wdata = lo_data_q;
        bus.mem_wstrb = lo_strb_q;
`endif
    end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: byte-level store model with a per-cycle beat/result scoreboard plus literal pins.
// Honours STORE_SPLIT_EN the same way as the design.
module tb_store_unit;
    import store_pkg::*;
`ifdef STORE_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0] s;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int vectors = 0;
    int miscompares = 0;
    int stall = 0;
    beat_t exp_beats[$];
    bit exp_res[$];
    logic pend = 1'b0;

    store_if bus();
    store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Each byte of the store goes to addr+i; bytes sharing a word form one beat.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int sz;
        int n;
        int lane;
        logic [31:0] ba;
        beat_t b[2];
        sz = f == 3'b000 ? 1 : f == 3'b001 ? 2 : f == 3'b010 ? 4 : 0;
        if (sz == 0 || (!SPLIT && (a % sz) != 0)) begin
            exp_res.push_back(1'b0);
            return;
        end
        n = 0;
        b[0] = '0;
        b[1] = '0;
        for (int i = 0; i < sz; i++) begin
            ba = a + 32'(i);
            if (n == 0 || b[n-1].a != {ba[31:2], 2'b00}) begin
                b[n].a = {ba[31:2], 2'b00};
                n++;
            end
            lane = int'(ba[1:0]);
            b[n-1].d[lane*8 +: 8] = d[i*8 +: 8];
            b[n-1].s[lane] = 1'b1;
        end
        for (int i = 0; i < n; i++) exp_beats.push_back(b[i]);
        exp_res.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        #2;
        bus.mem_ready = stall == 0;
        if (bus.mem_valid && stall > 0) stall--;
    end

    always @(negedge clk) begin
        if (rst) pend = 1'b0;
        else begin
            chk("done_err_excl", {31'b0, bus.done & bus.err}, 32'd0);
            chk("ready_vs_busy", {31'b0, bus.req_ready}, {31'b0, !bus.busy});
            if (pend) chk("valid_held", {31'b0, bus.mem_valid}, 32'd1);
            if (bus.mem_valid) begin
                chk("beat_expected", {31'b0, exp_beats.size() != 0}, 32'd1);
                if (exp_beats.size() != 0) begin
                    chk("beat_addr", bus.mem_addr, exp_beats[0].a);
                    chk("beat_wdata", bus.mem_wdata, exp_beats[0].d);
                    chk("beat_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, exp_beats[0].s});
                    if (bus.mem_ready) void'(exp_beats.pop_front());
                end
            end
            if (bus.done || bus.err) begin
                chk("result_expected", {31'b0, exp_res.size() != 0}, 32'd1);
                if (exp_res.size() != 0) begin
                    chk("result_kind", {30'b0, bus.done, bus.err}, exp_res[0] ? 32'd2 : 32'd1);
                    chk("beats_left", 32'(exp_beats.size()), 32'd0);
                    void'(exp_res.pop_front());
                end
            end
            pend = bus.mem_valid && !bus.mem_ready;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input int st);
        model(a, d, f);
        stall = st;
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        bus.req_data = d;
        bus.req_funct3 = f;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr = ~a;
        bus.req_data = ~d;
        bus.req_funct3 = 3'b111;
    endtask

    task automatic finish_wait();
        int g = 0;
        while (exp_res.size() != 0 && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("completion", 32'(exp_res.size()), 32'd0);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input int st);
        issue(a, d, f, st);
        finish_wait();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_funct3 = '0;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done_err", {30'b0, bus.done, bus.err}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
        @(posedge clk);
        #1;
        // SW aligned: one beat, done two edges after accept
        issue(32'h100, 32'hDEADBEEF, F3_SW, 0);
        @(negedge clk);
        chk("sw_pin_valid", {31'b0, bus.mem_valid}, 32'd1);
        chk("sw_pin_addr", bus.mem_addr, 32'h100);
        chk("sw_pin_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("sw_pin_wstrb", {28'b0, bus.mem_wstrb}, 32'hF);
        @(negedge clk);
        chk("sw_pin_done", {30'b0, bus.done, bus.err}, 32'd2);
        @(posedge clk);
        #1 finish_wait();
        // SB top lane
        issue(32'h203, 32'h123456AB, F3_SB, 0);
        @(negedge clk);
        chk("sb_pin_addr", bus.mem_addr, 32'h200);
        chk("sb_pin_wdata", bus.mem_wdata, 32'hAB000000);
        chk("sb_pin_wstrb", {28'b0, bus.mem_wstrb}, 32'h8);
        @(posedge clk);
        #1 finish_wait();
        // SH with memory stalled; new requests during the stall must be ignored
        issue(32'h102, 32'hFFFF1234, F3_SH, 3);
        bus.req_valid = 1'b1;
        bus.req_funct3 = F3_SW;
        @(negedge clk);
        chk("sh_pin_addr", bus.mem_addr, 32'h100);
        chk("sh_pin_wdata", bus.mem_wdata, 32'h12340000);
        chk("sh_pin_wstrb", {28'b0, bus.mem_wstrb}, 32'hC);
        @(negedge clk);
        chk("sh_pin_stable", bus.mem_wdata, 32'h12340000);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        finish_wait();
        // SW crossing the top of the address space
        issue(32'hFFFFFFFF, 32'h11223344, F3_SW, 0);
        @(negedge clk);
`ifdef STORE_SPLIT_EN
        chk("split_b1_addr", bus.mem_addr, 32'hFFFFFFFC);
        chk("split_b1_wdata", bus.mem_wdata, 32'h44000000);
        chk("split_b1_wstrb", {28'b0, bus.mem_wstrb}, 32'h8);
        @(negedge clk);
        chk("split_b2_addr", bus.mem_addr, 32'h00000000);
        chk("split_b2_wdata", bus.mem_wdata, 32'h00112233);
        chk("split_b2_wstrb", {28'b0, bus.mem_wstrb}, 32'h7);
`else
        chk("mis_err", {30'b0, bus.done, bus.err}, 32'd1);
        chk("mis_no_beat", {31'b0, bus.mem_valid}, 32'd0);
`endif
        @(posedge clk);
        #1 finish_wait();
        // assorted lanes, in-word and word-crossing halves, illegal funct3
        run(32'h401, 32'hFFFFFF5A, F3_SB, 0);
        run(32'h405, 32'hABCD9876, F3_SH, 1);
        run(32'h407, 32'h00004321, F3_SH, 0);
        run(32'h502, 32'h89ABCDEF, F3_SW, 2);
        run(32'h504, 32'h00000000, 3'b100, 0);
        run(32'hFFFFFFFC, 32'h0BADF00D, F3_SW, 1);
        run(32'h000, 32'h0000007F, F3_SB, 2);
        run(32'h606, 32'h5555AAAA, 3'b111, 0);
        // illegal funct3 then reset in the middle of a stalled SW
        issue(32'h000, 32'h12345678, 3'b011, 0);
        @(negedge clk);
        chk("f3_pin_err", {30'b0, bus.done, bus.err}, 32'd1);
        chk("f3_pin_novalid", {31'b0, bus.mem_valid}, 32'd0);
        @(posedge clk);
        #1 finish_wait();
        issue(32'h300, 32'hCAFEF00D, F3_SW, 10);
        @(posedge clk);
        #1;
        chk("rst_mid_in_lo", {31'b0, bus.mem_valid}, 32'd1);
        rst = 1'b1;
        exp_beats.delete();
        exp_res.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_mid_done_err", {30'b0, bus.done, bus.err}, 32'd0);
        rst = 1'b0;
        stall = 0;
        repeat (4) @(posedge clk);
        #1 run(32'h308, 32'h01020304, F3_SW, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
